cordic_vector: RTL and testbench

Iterative CORDIC vectoring engine: takes a complex sample (idata_r, idata_i) and returns its phase as a binary angle and its gain-compensated magnitude. It is the inverse of the `rotate` block, which turns a phase into a rotation. It sits ahead of `rotate` in carrier/phase-recovery loops, where it supplies the phase estimate that `rotate` later removes. It runs one sample at a time with a valid/ready handshake.

---
 rtl/cordic_vector.sv | 168 ++++++++++++++++
 tb/tb_cordic_vector.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vector.sv
// cordic_vector: iterative CORDIC vectoring engine.
// Converts one complex sample (idata_r, idata_i) into its binary-angle phase and its
// gain-compensated magnitude. One sample is in flight at a time; iready is high only in IDLE.
// Sequence per sample: IDLE -> PRE (half-plane fold) -> ITER x ITER -> SCALE -> IDLE.
// PHASE_WIDTH up to 32 is supported by the arctangent table.
module cordic_vector #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned PHASE_WIDTH = 16,
  parameter int unsigned ITER        = 14
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ivalid,
  output logic                         iready,
  input  logic signed [DATA_WIDTH-1:0] idata_r,
  input  logic signed [DATA_WIDTH-1:0] idata_i,
  output logic                         ovalid,
  output logic [PHASE_WIDTH-1:0]       phase,
  output logic [DATA_WIDTH:0]          magnitude
);

  // Two guard bits: CORDIC gain (~1.647) times sqrt(2) stays below 4.
  localparam int unsigned XW    = DATA_WIDTH + 2;
  localparam int unsigned PRODW = XW + 17;
  localparam int unsigned CW    = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [CW-1:0]          LastIter = CW'(ITER - 1);
  // 0x4DBA / 2^15 ~= 0.60725, the inverse of the accumulated CORDIC gain.
  localparam logic signed [16:0]     GainComp = 17'sd19898;
  localparam logic [PHASE_WIDTH-1:0] HalfTurn = {1'b1, {(PHASE_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StPre, StIter, StScale} state_e;

  // atan(2^-idx) with 2^32 units per full turn.
  function automatic logic [31:0] atan_full(input int unsigned idx);
    logic [31:0] t;
    case (idx)
      0:       t = 32'd536870912;
      1:       t = 32'd316933406;
      2:       t = 32'd167458907;
      3:       t = 32'd85004756;
      4:       t = 32'd42667331;
      5:       t = 32'd21354465;
      6:       t = 32'd10679838;
      7:       t = 32'd5340245;
      8:       t = 32'd2670163;
      9:       t = 32'd1335087;
      10:      t = 32'd667544;
      11:      t = 32'd333772;
      12:      t = 32'd166886;
      13:      t = 32'd83443;
      14:      t = 32'd41722;
      15:      t = 32'd20861;
      // Small-angle region: atan(2^-i) ~= 2^-i, i.e. round(2^32 / (2*pi) / 2^i).
      default: t = 32'((64'd683565276 + (64'd1 << (idx - 1))) >> idx);
    endcase
    return t;
  endfunction

  // Round the 32-bit table entry to PHASE_WIDTH bits per turn.
  function automatic logic [PHASE_WIDTH-1:0] atan_entry(input int unsigned idx);
    logic [63:0] t;
    t = {32'd0, atan_full(idx)};
    if (PHASE_WIDTH < 32) begin
      t = (t + (64'd1 << (31 - PHASE_WIDTH))) >> (32 - PHASE_WIDTH);
    end
    return t[PHASE_WIDTH-1:0];
  endfunction

  state_e                   r_state;
  logic [CW-1:0]            r_cnt;
  logic signed [XW-1:0]     r_x;
  logic signed [XW-1:0]     r_y;
  logic [PHASE_WIDTH-1:0]   r_z;
  logic                     r_zero;
  logic                     r_ovalid;
  logic [PHASE_WIDTH-1:0]   r_phase;
  logic [DATA_WIDTH:0]      r_mag;

  logic [PHASE_WIDTH-1:0]   w_atan_tab [ITER];
  logic [PHASE_WIDTH-1:0]   w_atan;
  logic signed [XW-1:0]     w_xs;
  logic signed [XW-1:0]     w_ys;
  logic signed [PRODW-1:0]  w_prod;
  logic [DATA_WIDTH:0]      w_mag;
  logic                     w_unused_prod;

  for (genvar g = 0; g < ITER; g++) begin : g_atan
    assign w_atan_tab[g] = atan_entry(g);
  end

  assign w_atan = w_atan_tab[r_cnt];
  assign w_xs   = r_x >>> r_cnt;
  assign w_ys   = r_y >>> r_cnt;

  // x is non-negative after the fold and only grows, so the product is non-negative.
  assign w_prod        = PRODW'(r_x) * PRODW'(GainComp);
  assign w_mag         = w_prod[DATA_WIDTH+15:15];
  assign w_unused_prod = ^{w_prod[PRODW-1:DATA_WIDTH+16], w_prod[14:0]};

  assign iready    = (r_state == StIdle);
  assign ovalid    = r_ovalid;
  assign phase     = r_phase;
  assign magnitude = r_mag;

  // FSM, datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_zero   <= 1'b0;
      r_ovalid <= 1'b0;
      r_phase  <= '0;
      r_mag    <= '0;
    end else begin
      r_ovalid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (ivalid) begin
            r_x     <= {{2{idata_r[DATA_WIDTH-1]}}, idata_r};
            r_y     <= {{2{idata_i[DATA_WIDTH-1]}}, idata_i};
            r_z     <= '0;
            r_state <= StPre;
          end
        end
        StPre: begin
          // Fold the left half-plane onto the right so the iterations only need +-90 deg.
          if (r_x[XW-1]) begin
            r_x <= -r_x;
            r_y <= -r_y;
            r_z <= HalfTurn;
          end
          r_zero  <= (r_x == '0) && (r_y == '0);
          r_cnt   <= '0;
          r_state <= StIter;
        end
        StIter: begin
          // Rotate towards the positive x axis; both updates use the old x and y.
          if (!r_y[XW-1]) begin
            r_x <= r_x + w_ys;
            r_y <= r_y - w_xs;
            r_z <= r_z + w_atan;
          end else begin
            r_x <= r_x - w_ys;
            r_y <= r_y + w_xs;
            r_z <= r_z - w_atan;
          end
          if (r_cnt == LastIter) begin
            r_state <= StScale;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StScale: begin
          // A zero input has no defined angle; report 0 for both results.
          r_phase  <= r_zero ? '0 : r_z;
          r_mag    <= r_zero ? '0 : w_mag;
          r_ovalid <= 1'b1;
          r_state  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_vector.sv
// tb_cordic_vector: self-checking bench for cordic_vector.
// Expected phase and magnitude come from atan2/sqrt on the raw input.
`timescale 1ns/1ps
module tb_cordic_vector;

  localparam int DW     = 16;
  localparam int PW     = 16;
  localparam int NIT    = 14;
  // ovalid is the 17th edge counting the accepting edge as the first.
  localparam int LAT    = NIT + 2;
  localparam int PERIOD = NIT + 3;
  localparam real TwoPi = 6.283185307179586;
  localparam int TolPh  = 8;
  localparam int TolMg  = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          ivalid = 1'b0;
  logic          iready;
  logic [DW-1:0] idata_r = '0;
  logic [DW-1:0] idata_i = '0;
  logic          ovalid;
  logic [PW-1:0] phase;
  logic [DW:0]   magnitude;

  int checks = 0;
  int errors = 0;

  cordic_vector #(
    .DATA_WIDTH (DW),
    .PHASE_WIDTH(PW),
    .ITER       (NIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .ivalid   (ivalid),
    .iready   (iready),
    .idata_r  (idata_r),
    .idata_i  (idata_i),
    .ovalid   (ovalid),
    .phase    (phase),
    .magnitude(magnitude)
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int ref_phase(int re, int im);
    real a;
    a = $atan2(real'(im), real'(re)) * 65536.0 / TwoPi;
    return int'(a);
  endfunction

  function automatic int ref_mag(int re, int im);
    return int'($sqrt(real'(re) * real'(re) + real'(im) * real'(im)));
  endfunction

  // Circular distance between two angles on a 2^16 turn.
  function automatic int phase_dist(int got, int want);
    int d;
    d = (got - want) % 65536;
    if (d < 0) d += 65536;
    if (d >= 32768) d = 65536 - d;
    return d;
  endfunction

  function automatic int abs_diff(int a, int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Present one sample, then wait (bounded) for its result. lat counts edges after accept.
  task automatic run_sample(input int re, input int im, output int ph, output int mg,
                            output int lat, output bit got);
    int guard;
    ph = 0; mg = 0; lat = 0; got = 1'b0; guard = 0;
    @(negedge clock);
    while (!iready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    ivalid  = 1'b1;
    idata_r = re[15:0];
    idata_i = im[15:0];
    @(posedge clock); #1;
    ivalid  = 1'b0;
    idata_r = 16'($urandom);
    idata_i = 16'($urandom);
    for (int k = 1; k <= LAT + 10; k++) begin
      @(posedge clock); #1;
      if (ovalid) begin
        ph  = int'(phase);
        mg  = int'(magnitude);
        lat = k;
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("FAIL reset_ovalid: got %0b, expected 0", ovalid);
    end
    checks++;
    if (iready !== 1'b1) begin
      errors++; $display("FAIL reset_iready: got %0b, expected 1", iready);
    end
    checks++;
    if (phase !== '0) begin
      errors++; $display("FAIL reset_phase: got %0d, expected 0", phase);
    end
    checks++;
    if (magnitude !== '0) begin
      errors++; $display("FAIL reset_magnitude: got %0d, expected 0", magnitude);
    end
  endtask

  task automatic test_directed();
    int re [8] = '{16384, 0, 0, -16384, -16384, -16384, 10000, -32768};
    int im [8] = '{0, 16384, -16384, 0, 1, -1, -10000, -32768};
    int eph[8] = '{0, 'h4000, 'hC000, 'h8000, 'h8000, 'h8000, 'hE000, 'hA000};
    int emg[8] = '{16384, 16384, 0, 16384, 0, 0, 14142, 46341};
    int tmg[8] = '{3, 3, 0, 3, 0, 0, 3, 4};
    int ph, mg, lat;
    bit got;
    for (int n = 0; n < 8; n++) begin
      run_sample(re[n], im[n], ph, mg, lat, got);
      checks++;
      if (!got || lat != LAT) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d (seen %0b), expected %0d", n, lat, got, LAT);
      end
      checks++;
      if (phase_dist(ph, eph[n]) > 4) begin
        errors++;
        $display("FAIL dir_phase[%0d]: got 0x%04h, expected 0x%04h +/- 4", n, ph, eph[n]);
      end
      if (tmg[n] != 0) begin
        checks++;
        if (abs_diff(mg, emg[n]) > tmg[n]) begin
          errors++;
          $display("FAIL dir_magnitude[%0d]: got %0d, expected %0d +/- %0d",
                   n, mg, emg[n], tmg[n]);
        end
      end
    end
  endtask

  task automatic test_zero();
    int ph, mg, lat;
    bit got;
    run_sample(0, 0, ph, mg, lat, got);
    checks++;
    if (!got || lat != LAT) begin
      errors++; $display("FAIL zero_latency: got %0d (seen %0b), expected %0d", lat, got, LAT);
    end
    checks++;
    if (ph != 0) begin
      errors++; $display("FAIL zero_phase: got %0d, expected 0", ph);
    end
    checks++;
    if (mg != 0) begin
      errors++; $display("FAIL zero_magnitude: got %0d, expected 0", mg);
    end
    @(posedge clock); #1;
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("FAIL ovalid_width: got %0b one cycle later, expected 0", ovalid);
    end
  endtask

  task automatic test_random();
    int re, im, ph, mg, lat;
    bit got;
    for (int n = 0; n < 40; n++) begin
      do begin
        re = int'($urandom_range(65535)) - 32768;
        im = int'($urandom_range(65535)) - 32768;
      end while (re * re + im * im < 8192 * 8192);
      run_sample(re, im, ph, mg, lat, got);
      checks++;
      if (!got || lat != LAT) begin
        errors++;
        $display("FAIL rnd_latency(%0d,%0d): got %0d (seen %0b), expected %0d",
                 re, im, lat, got, LAT);
      end
      checks++;
      if (phase_dist(ph, ref_phase(re, im)) > TolPh) begin
        errors++;
        $display("FAIL rnd_phase(%0d,%0d): got %0d, expected %0d +/- %0d",
                 re, im, ph, ref_phase(re, im) & 65535, TolPh);
      end
      checks++;
      if (abs_diff(mg, ref_mag(re, im)) > TolMg) begin
        errors++;
        $display("FAIL rnd_magnitude(%0d,%0d): got %0d, expected %0d +/- %0d",
                 re, im, mg, ref_mag(re, im), TolMg);
      end
    end
  endtask

  // ivalid held high for three samples with junk data on every busy cycle.
  task automatic test_back_to_back();
    int sr[3] = '{20000, -7000, 3000};
    int si[3] = '{5000, -25000, -30000};
    int p_edge[$];
    int p_ph[$];
    int p_mg[$];
    int bad_ready = 0;
    int guard = 0;
    bit exp_ready;
    @(negedge clock);
    while (!iready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    ivalid  = 1'b1;
    idata_r = sr[0][15:0];
    idata_i = si[0][15:0];
    @(posedge clock); #1;
    for (int c = 1; c <= 3 * PERIOD + 10; c++) begin
      @(negedge clock);
      ivalid = (c <= 2 * PERIOD);
      if (c <= 2 * PERIOD && c % PERIOD == 0) begin
        idata_r = sr[c / PERIOD][15:0];
        idata_i = si[c / PERIOD][15:0];
      end else begin
        idata_r = 16'($urandom);
        idata_i = 16'($urandom);
      end
      @(posedge clock); #1;
      if (ovalid) begin
        p_edge.push_back(c);
        p_ph.push_back(int'(phase));
        p_mg.push_back(int'(magnitude));
      end
      exp_ready = (c % PERIOD == PERIOD - 1) || (c >= 3 * PERIOD - 1);
      if (iready !== exp_ready) bad_ready++;
    end
    ivalid = 1'b0;
    checks++;
    if (p_edge.size() != 3) begin
      errors++; $display("FAIL b2b_pulse_count: got %0d, expected 3", p_edge.size());
    end
    checks++;
    if (bad_ready != 0) begin
      errors++; $display("FAIL b2b_iready_window: got %0d wrong cycles, expected 0", bad_ready);
    end
    for (int k = 0; k < p_edge.size() && k < 3; k++) begin
      checks++;
      if (p_edge[k] != k * PERIOD + LAT) begin
        errors++;
        $display("FAIL b2b_edge[%0d]: got %0d, expected %0d", k, p_edge[k], k * PERIOD + LAT);
      end
      checks++;
      if (phase_dist(p_ph[k], ref_phase(sr[k], si[k])) > TolPh) begin
        errors++;
        $display("FAIL b2b_phase[%0d]: got %0d, expected %0d", k, p_ph[k],
                 ref_phase(sr[k], si[k]) & 65535);
      end
      checks++;
      if (abs_diff(p_mg[k], ref_mag(sr[k], si[k])) > TolMg) begin
        errors++;
        $display("FAIL b2b_magnitude[%0d]: got %0d, expected %0d", k, p_mg[k],
                 ref_mag(sr[k], si[k]));
      end
    end
  endtask

  task automatic test_reset_mid();
    int ph, mg, lat;
    int seen = 0;
    bit got;
    @(negedge clock);
    ivalid  = 1'b1;
    idata_r = 16'd15000;
    idata_i = 16'(-6000);
    @(posedge clock); #1;
    ivalid = 1'b0;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if (ovalid !== 1'b0) begin
      errors++; $display("FAIL midrst_ovalid: got %0b, expected 0", ovalid);
    end
    checks++;
    if (iready !== 1'b1) begin
      errors++; $display("FAIL midrst_iready: got %0b, expected 1", iready);
    end
    checks++;
    if (phase !== '0) begin
      errors++; $display("FAIL midrst_phase: got %0d, expected 0", phase);
    end
    checks++;
    if (magnitude !== '0) begin
      errors++; $display("FAIL midrst_magnitude: got %0d, expected 0", magnitude);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (ovalid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_stale_ovalid: got %0d pulses, expected 0", seen);
    end
    run_sample(12000, 9000, ph, mg, lat, got);
    checks++;
    if (!got || lat != LAT) begin
      errors++; $display("FAIL midrst_latency: got %0d (seen %0b), expected %0d", lat, got, LAT);
    end
    checks++;
    if (phase_dist(ph, ref_phase(12000, 9000)) > TolPh) begin
      errors++;
      $display("FAIL midrst_phase: got %0d, expected %0d", ph, ref_phase(12000, 9000));
    end
    checks++;
    if (abs_diff(mg, ref_mag(12000, 9000)) > TolMg) begin
      errors++;
      $display("FAIL midrst_magnitude: got %0d, expected %0d", mg, ref_mag(12000, 9000));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
